pkt_cfg_decoder: RTL and testbench

PKT_CFG_DECODER -- requirements
Module: pkt_cfg_decoder

---
 rtl/hssl_pkg.sv | 35 +++
 rtl/pkt_skid_buffer.sv | 55 +++++
 rtl/pkt_cfg_decoder.sv | 79 +++++++
 tb/tb_pkt_cfg_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssl_pkg.sv
// Shared packet layout, type codes and parity helper for the HSSL packet path.
package hssl_pkg;

    localparam int unsigned PKT_W  = 72;
    localparam int unsigned PLD_W  = 32;
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PFX_W  = KEY_W - ADDR_W;

    typedef enum logic [1:0] {
        PKT_TYPE_MCAST = 2'b00
    } pkt_type_e;

    // Header bit positions: [7:6] type, [5:2] reserved, [1] payload present, [0] parity
    typedef struct packed {
        pkt_type_e  ptype;
        logic [3:0] rsvd;
        logic       pld_present;
        logic       parity;
    } pkt_hdr_t;

    typedef struct packed {
        logic [PLD_W-1:0] payload;
        logic [KEY_W-1:0] key;
        pkt_hdr_t         header;
    } pkt_t;

    // Odd parity over header and key, plus payload only when it is present
    function automatic logic pkt_parity_ok(input pkt_t p);
        logic [PLD_W-1:0] pld;
        pld = p.header.pld_present ? p.payload : '0;
        return ^{pld, p.key, p.header};
    endfunction

endpackage

// File: rtl/pkt_skid_buffer.sv
// Two-entry in-order skid buffer with registered ready, valid and data.
module pkt_skid_buffer #(
    parameter int unsigned DATA_W = 72
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_vld,
    output logic              s_rdy,
    output logic [DATA_W-1:0] m_data,
    output logic              m_vld,
    input  logic              m_rdy
);

    logic [1:0]        cnt_q;
    logic [1:0]        cnt_nxt;
    logic [DATA_W-1:0] ent1_q;
    logic              push;
    logic              pop;
    logic              wr_slot;

    // Occupancy bookkeeping; the write slot is the first free one after any pop
    always_comb begin
        push    = s_vld && s_rdy;
        pop     = m_vld && m_rdy;
        cnt_nxt = cnt_q + 2'(push) - 2'(pop);
        wr_slot = (cnt_q - 2'(pop)) != 2'd0;
    end

    // Head entry drives the output directly; second entry shifts in on pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= 2'd0;
            s_rdy  <= 1'b0;
            m_vld  <= 1'b0;
            m_data <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            s_rdy <= cnt_nxt != 2'd2;
            m_vld <= cnt_nxt != 2'd0;
            if (pop) begin
                m_data <= ent1_q;
            end
            if (push) begin
                if (wr_slot) begin
                    ent1_q <= s_data;
                end else begin
                    m_data <= s_data;
                end
            end
        end
    end

endmodule

// File: rtl/pkt_cfg_decoder.sv
// Splits incoming packets into register writes, drops and forwarded traffic.
module pkt_cfg_decoder
    import hssl_pkg::*;
#(
    parameter logic [23:0] CFG_KEY_PFX = 24'hffff_fe,
    parameter int unsigned NUM_CTRS    = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [PKT_W-1:0]    pkt_data_in,
    input  logic                pkt_vld_in,
    output logic                pkt_rdy_out,
    output logic [PKT_W-1:0]    fwd_data_out,
    output logic                fwd_vld_out,
    input  logic                fwd_rdy_in,
    output logic [ADDR_W-1:0]   prx_addr_out,
    output logic [PLD_W-1:0]    prx_data_out,
    output logic                prx_vld_out,
    output logic [NUM_CTRS-1:0] ctr_cnt_out
);

    pkt_t                pkt;
    logic                accept;
    logic                par_ok;
    logic                is_cfg;
    logic                cfg_wr;
    logic                drop;
    logic                fwd_class;
    logic                fwd_hs;
    logic [NUM_CTRS-1:0] ctr_nxt;

    // Classify the packet currently on the input
    always_comb begin
        pkt       = pkt_t'(pkt_data_in);
        accept    = pkt_vld_in && pkt_rdy_out;
        par_ok    = pkt_parity_ok(pkt);
        is_cfg    = par_ok && (pkt.header.ptype == PKT_TYPE_MCAST)
                    && (pkt.key[KEY_W-1:ADDR_W] == CFG_KEY_PFX);
        cfg_wr    = accept && is_cfg && pkt.header.pld_present;
        drop      = !par_ok || (is_cfg && !pkt.header.pld_present);
        fwd_class = par_ok && !is_cfg;
        fwd_hs    = fwd_vld_out && fwd_rdy_in;
        ctr_nxt    = '0;
        ctr_nxt[0] = fwd_hs;
        ctr_nxt[1] = accept && drop;
    end

    // Register write strobe and counter pulses, one cycle after the event
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prx_vld_out  <= 1'b0;
            prx_addr_out <= '0;
            prx_data_out <= '0;
            ctr_cnt_out  <= '0;
        end else begin
            prx_vld_out <= cfg_wr;
            ctr_cnt_out <= ctr_nxt;
            if (cfg_wr) begin
                prx_addr_out <= pkt.key[ADDR_W-1:0];
                prx_data_out <= pkt.payload;
            end
        end
    end

    // Forward path; its ready doubles as the input ready for every packet class
    pkt_skid_buffer #(
        .DATA_W (PKT_W)
    ) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .s_data (pkt_data_in),
        .s_vld  (pkt_vld_in && fwd_class),
        .s_rdy  (pkt_rdy_out),
        .m_data (fwd_data_out),
        .m_vld  (fwd_vld_out),
        .m_rdy  (fwd_rdy_in)
    );

endmodule

// File: tb/tb_pkt_cfg_decoder.sv
// Randomized scoreboard bench for pkt_cfg_decoder with directed corner cases.
module tb_pkt_cfg_decoder;

    localparam logic [23:0] PFX = 24'hffff_fe;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [71:0] pkt_data_in = '0;
    logic        pkt_vld_in = 1'b0;
    logic        pkt_rdy_out;
    logic [71:0] fwd_data_out;
    logic        fwd_vld_out;
    logic        fwd_rdy_in = 1'b0;
    logic [7:0]  prx_addr_out;
    logic [31:0] prx_data_out;
    logic        prx_vld_out;
    logic [1:0]  ctr_cnt_out;

    pkt_cfg_decoder #(.CFG_KEY_PFX(PFX), .NUM_CTRS(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pkt_data_in  (pkt_data_in),
        .pkt_vld_in   (pkt_vld_in),
        .pkt_rdy_out  (pkt_rdy_out),
        .fwd_data_out (fwd_data_out),
        .fwd_vld_out  (fwd_vld_out),
        .fwd_rdy_in   (fwd_rdy_in),
        .prx_addr_out (prx_addr_out),
        .prx_data_out (prx_data_out),
        .prx_vld_out  (prx_vld_out),
        .ctr_cnt_out  (ctr_cnt_out)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          due;
    } prx_exp_t;

    logic [71:0] fwd_q[$];
    prx_exp_t    prx_q[$];
    int          drop_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int ctr0_cnt = 0;
    bit rdy_rand = 1'b0;
    bit p_done = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Random downstream backpressure when enabled
    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) fwd_rdy_in = ($urandom % 4) != 0;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Build a packet with correct odd parity, optionally corrupted
    function automatic logic [71:0] mk(input logic [31:0] key, input logic [31:0] pl,
                                       input logic [1:0] ty, input bit pld, input bit bad);
        logic [7:0] h;
        int ones;
        h = {ty, 4'($urandom), pld, 1'b0};
        ones = $countones(h) + $countones(key) + (pld ? $countones(pl) : 0);
        h[0] = ((ones % 2) == 0) ^ bad;
        return {pl, key, h};
    endfunction

    // Reference model: predicts the outcome of an accepted packet
    task automatic model(input logic [71:0] p);
        logic [7:0]  h;
        logic [31:0] key;
        logic [31:0] pl;
        int ones;
        bit ok;
        bit cfg;
        h = p[7:0];
        key = p[39:8];
        pl = p[71:40];
        ones = $countones(h) + $countones(key) + (h[1] ? $countones(pl) : 0);
        ok = (ones % 2) == 1;
        cfg = ok && (h[7:6] == 2'b00) && (key[31:8] == PFX);
        if (!ok || (cfg && !h[1])) drop_q.push_back(cyc + 1);
        else if (cfg) prx_q.push_back('{a: key[7:0], d: pl, due: cyc + 1});
        else fwd_q.push_back(p);
    endtask

    // Present a packet until it is accepted; expectation is queued at acceptance
    task automatic send(input logic [71:0] d);
        int w;
        w = 0;
        pkt_vld_in = 1'b1;
        pkt_data_in = d;
        @(negedge clk);
        while (!pkt_rdy_out && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!pkt_rdy_out) chk("send_timeout", 72'(pkt_rdy_out), 72'd1);
        else model(d);
        @(posedge clk); #1;
        pkt_vld_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, 72'(pkt_rdy_out), 72'd0);
        chk({tag, "_fwd_vld"}, 72'(fwd_vld_out), 72'd0);
        chk({tag, "_fwd_data"}, fwd_data_out, 72'd0);
        chk({tag, "_prx_vld"}, 72'(prx_vld_out), 72'd0);
        chk({tag, "_prx_addr"}, 72'(prx_addr_out), 72'd0);
        chk({tag, "_prx_data"}, 72'(prx_data_out), 72'd0);
        chk({tag, "_ctr"}, 72'(ctr_cnt_out), 72'd0);
    endtask

    // Monitor: compares every DUT output event against the scoreboard
    logic [71:0] prev_data;
    bit prev_stall = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("fwd_hold_vld", 72'(fwd_vld_out), 72'd1);
                chk("fwd_hold_data", fwd_data_out, prev_data);
            end
            if (fwd_vld_out && fwd_rdy_in) begin
                hs_cnt++;
                if (fwd_q.size() == 0) chk("fwd_unexpected", 72'(fwd_vld_out), 72'd0);
                else chk("fwd_data", fwd_data_out, fwd_q.pop_front());
            end
            if (prx_q.size() != 0 && prx_q[0].due < cyc) begin
                chk("prx_missed", 72'(prx_vld_out), 72'd1);
                void'(prx_q.pop_front());
            end
            if (prx_vld_out) begin
                if (prx_q.size() == 0) chk("prx_unexpected", 72'(prx_vld_out), 72'd0);
                else begin
                    prx_exp_t e;
                    e = prx_q.pop_front();
                    chk("prx_cycle", 72'(cyc), 72'(e.due));
                    chk("prx_addr", 72'(prx_addr_out), 72'(e.a));
                    chk("prx_data", 72'(prx_data_out), 72'(e.d));
                end
            end
            if (drop_q.size() != 0 && drop_q[0] < cyc) begin
                chk("drop_missed", 72'(ctr_cnt_out[1]), 72'd1);
                void'(drop_q.pop_front());
            end
            if (ctr_cnt_out[1]) begin
                if (drop_q.size() == 0) chk("drop_unexpected", 72'(ctr_cnt_out[1]), 72'd0);
                else chk("drop_cycle", 72'(cyc), 72'(drop_q.pop_front()));
            end
            if (ctr_cnt_out[0]) begin
                ctr0_cnt++;
                chk("ctr0_excess", 72'(ctr0_cnt <= hs_cnt), 72'd1);
            end
            prev_stall = fwd_vld_out && !fwd_rdy_in;
            prev_data = fwd_data_out;
        end
    end

    initial begin
        int w;
        // Reset state and ready rising after release
        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", 72'(pkt_rdy_out), 72'd0);
        @(negedge clk);
        chk("rdy_after_release", 72'(pkt_rdy_out), 72'd1);
        @(posedge clk); #1;
        fwd_rdy_in = 1'b1;

        // Directed classification cases
        send(mk(32'hffff_fe14, 32'h0000_0003, 2'b00, 1'b1, 1'b0));
        idle(3);
        send(mk(32'h1234_5678, $urandom, 2'b01, 1'b1, 1'b0));
        idle(3);
        send(mk(32'h1234_5678, 32'h0000_dead, 2'b00, 1'b1, 1'b1));
        send(mk(32'hffff_fe20, 32'h0, 2'b00, 1'b0, 1'b0));
        send(mk(32'hffff_fe33, $urandom, 2'b10, 1'b1, 1'b0));
        send(mk(32'h0bad_cafe, $urandom, 2'b00, 1'b0, 1'b0));
        idle(4);

        // Fill the buffer with output stalled, then queue a config and a third forward
        fwd_rdy_in = 1'b0;
        send(mk(32'h0000_0001, 32'h1111_1111, 2'b01, 1'b1, 1'b0));
        send(mk(32'h0000_0002, 32'h2222_2222, 2'b01, 1'b1, 1'b0));
        @(negedge clk);
        chk("rdy_full", 72'(pkt_rdy_out), 72'd0);
        p_done = 1'b0;
        fork
            begin
                send(mk(32'hffff_fe44, 32'h4444_4444, 2'b00, 1'b1, 1'b0));
                send(mk(32'h0000_0003, 32'h3333_3333, 2'b01, 1'b1, 1'b0));
                p_done = 1'b1;
            end
        join_none
        repeat (3) begin
            @(negedge clk);
            chk("rdy_stalled", 72'(pkt_rdy_out), 72'd0);
        end
        @(posedge clk); #1;
        fwd_rdy_in = 1'b1;
        @(negedge clk);
        chk("rdy_release_same", 72'(pkt_rdy_out), 72'd0);
        @(negedge clk);
        chk("rdy_release_next", 72'(pkt_rdy_out), 72'd1);
        w = 0;
        while (!p_done && w < 100) begin @(posedge clk); w++; end
        chk("stall_sends_done", 72'(p_done), 72'd1);
        idle(6);

        // Reset with two packets buffered: they must vanish
        fwd_rdy_in = 1'b0;
        send(mk(32'h0000_0005, $urandom, 2'b11, 1'b1, 1'b0));
        send(mk(32'h0000_0006, $urandom, 2'b11, 1'b1, 1'b0));
        idle(2);
        resetn = 1'b0;
        fwd_q.delete();
        @(negedge clk);
        chk_zero("midreset");
        idle(2);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rdy_after_midreset", 72'(pkt_rdy_out), 72'd1);
        @(posedge clk); #1;
        fwd_rdy_in = 1'b1;
        idle(6);

        // Randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bit cfgish;
            logic [31:0] key;
            logic [1:0] ty;
            cfgish = ($urandom % 8) < 3;
            key = cfgish ? {PFX, 8'($urandom)} : $urandom;
            ty = (cfgish && ($urandom % 4) != 0) ? 2'b00 : 2'($urandom);
            send(mk(key, $urandom, ty, 1'($urandom), ($urandom % 8) == 0));
            if (($urandom % 4) == 0) idle($urandom_range(0, 2));
        end

        // Drain and final accounting
        rdy_rand = 1'b0;
        fwd_rdy_in = 1'b1;
        w = 0;
        while ((fwd_q.size() != 0 || prx_q.size() != 0 || drop_q.size() != 0) && w < 500) begin
            @(posedge clk); w++;
        end
        idle(3);
        chk("fwd_q_empty", 72'(fwd_q.size()), 72'd0);
        chk("prx_q_empty", 72'(prx_q.size()), 72'd0);
        chk("drop_q_empty", 72'(drop_q.size()), 72'd0);
        chk("ctr0_total", 72'(ctr0_cnt), 72'(hs_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
